// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - glitch-free programmable clock divider controller
// Ratio changes are staged while running and take effect only at a falling boundary of clk_out.
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int RST_DIV = 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             running
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_e;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_DIV_V = CNT_W'(RST_DIV);

  state_e           state_q, state_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;

  logic             xfer;
  logic             terminal;
  logic [CNT_W-1:0] cfg_val;
  logic [CNT_W-1:0] next_div;

  assign xfer      = cfg_valid & ~pend_q;
  assign cfg_val   = (cfg_div == '0) ? ONE : cfg_div;
  assign next_div  = pend_q ? pend_div_q : cur_div_q;
  assign terminal  = (cnt_q == '0);

  assign cfg_ready = ~pend_q;
  assign clk_out   = clk_q;
  assign rise_stb  = rise_q;
  assign running   = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    clk_d      = clk_q;
    rise_d     = 1'b0;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;

    case (state_q)
      S_IDLE: begin
        clk_d = 1'b0;
        if (xfer) cur_div_d = cfg_val;
        if (en) begin
          state_d = S_RUN;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = (xfer ? cfg_val : cur_div_q) - ONE;
        end
      end

      S_RUN, S_STOP: begin
        if (xfer) begin
          pend_div_d = cfg_val;
          pend_d     = 1'b1;
        end
        if (state_q == S_RUN && !clk_q && !en) begin
          // Low phase may be cut short: stopping here cannot create a runt high pulse.
          state_d = S_IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
          cur_div_d = xfer ? cfg_val : next_div;
        end else if (state_q == S_STOP || !en) begin
          state_d = S_STOP;
          if (terminal) begin
            clk_d = 1'b0;
            if (pend_q) begin
              cur_div_d = pend_div_q;
              pend_d    = 1'b0;
            end
            if (en) begin
              state_d = S_RUN;
              cnt_d   = next_div - ONE;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
              if (xfer) begin
                cur_div_d = cfg_val;
                pend_d    = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end else if (terminal) begin
          if (clk_q) begin
            clk_d = 1'b0;
            if (pend_q) begin
              cur_div_d = pend_div_q;
              pend_d    = 1'b0;
            end
            cnt_d = next_div - ONE;
          end else begin
            clk_d  = 1'b1;
            rise_d = 1'b1;
            cnt_d  = cur_div_q - ONE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        clk_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      cur_div_q  <= RST_DIV_V;
      pend_div_q <= RST_DIV_V;
    end else begin
      state_q    <= state_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl
// Phase-age model of the divided clock, plus literal waveforms for the listed scenarios.
module tb_clk_div_ctrl;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready, clk_out, rise_stb, running;

  clk_div_ctrl #(.CNT_W(8), .RST_DIV(1)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .clk_out  (clk_out),
    .rise_stb (rise_stb),
    .running  (running)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  // Model: the divided clock as phases; m_age counts edges since the last toggle.
  bit m_run = 0, m_stop = 0, m_clk = 0, m_rise = 0, m_pend = 0;
  int m_age = 0, m_div = 1, m_pdiv = 1;

  task automatic model_step();
    bit x;
    bit idle_now;
    int dv;
    x = cfg_valid && !m_pend;
    dv = (cfg_div == 0) ? 1 : int'(cfg_div);
    idle_now = 0;
    m_rise = 0;
    if (!m_run) begin
      if (x) m_div = dv;
      if (en) begin
        m_run = 1; m_stop = 0; m_clk = 1; m_rise = 1; m_age = 0;
      end
    end else if (!en && !m_clk) begin
      m_run = 0;
      if (m_pend) m_div = m_pdiv;
      if (x) m_div = dv;
      m_pend = 0;
    end else begin
      if (!en) m_stop = 1;
      if (m_age == m_div - 1) begin
        m_age = 0;
        if (m_clk) begin
          m_clk = 0;
          if (m_pend) begin m_div = m_pdiv; m_pend = 0; end
          if (m_stop) begin
            m_stop = 0;
            if (!en) idle_now = 1;
          end
        end else begin
          m_clk = 1; m_rise = 1;
        end
      end else begin
        m_age++;
      end
      if (idle_now) begin
        m_run = 0;
        if (x) m_div = dv;
      end else if (x) begin
        m_pdiv = dv; m_pend = 1;
      end
    end
  endtask

  always @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_stop = 0; m_clk = 0; m_rise = 0; m_pend = 0;
      m_age = 0; m_div = 1; m_pdiv = 1;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (started) begin
      chk("model_clk_out", clk_out, m_clk);
      chk("model_rise_stb", rise_stb, m_rise);
      chk("model_running", running, m_run);
      chk("model_cfg_ready", cfg_ready, !m_pend);
    end
  end

  task automatic step(input bit e, input bit v, input logic [7:0] d);
    en = e; cfg_valid = v; cfg_div = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    en = 0; cfg_valid = 0; cfg_div = 0;
    rst = 0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst = 1;
  endtask

  // Patterns are read MSB first: bit n-1 is the value after the first edge.
  task automatic expect_seq(input string nm, input bit e, input bit v, input logic [7:0] d,
                            input int n, input logic [31:0] p_clk, input logic [31:0] p_rise,
                            input logic [31:0] p_run, input logic [31:0] p_rdy);
    for (int i = 0; i < n; i++) begin
      step(e, v, d);
      chk({nm, "_clk"}, clk_out, p_clk[n-1-i]);
      chk({nm, "_rise"}, rise_stb, p_rise[n-1-i]);
      chk({nm, "_run"}, running, p_run[n-1-i]);
      chk({nm, "_rdy"}, cfg_ready, p_rdy[n-1-i]);
    end
  endtask

  initial begin
    do_reset();
    started = 1;
    chk("reset_clk", clk_out, 1'b0);
    chk("reset_rise", rise_stb, 1'b0);
    chk("reset_run", running, 1'b0);
    chk("reset_rdy", cfg_ready, 1'b1);

    // div = 3: 3 high / 3 low
    step(0, 1, 8'd3);
    expect_seq("div3", 1, 0, 8'd0, 12, 32'b111000111000, 32'b100000100000,
               32'hFFF, 32'hFFF);

    // div = 0 behaves as div = 1
    do_reset();
    step(0, 1, 8'd0);
    expect_seq("div0", 1, 0, 8'd0, 4, 32'b1010, 32'b1010, 32'hF, 32'hF);

    // 3 -> 5 accepted one cycle into a high phase
    do_reset();
    step(0, 1, 8'd3);
    step(1, 0, 8'd0);
    expect_seq("cfg_acc", 1, 1, 8'd5, 1, 32'b1, 32'b0, 32'b1, 32'b0);
    expect_seq("cfg_chg", 1, 0, 8'd0, 12, 32'b100000111110, 32'b000000100000,
               32'hFFF, 32'b011111111111);

    // stop one cycle after rise at div = 4
    do_reset();
    step(0, 1, 8'd4);
    step(1, 0, 8'd0);
    expect_seq("stop", 0, 0, 8'd0, 5, 32'b11100, 32'b0, 32'b11100, 32'h1F);

    // stop, then re-enable before terminal count
    do_reset();
    step(0, 1, 8'd4);
    step(1, 0, 8'd0);
    expect_seq("reen_drop", 0, 0, 8'd0, 1, 32'b1, 32'b0, 32'b1, 32'b1);
    expect_seq("reen", 1, 0, 8'd0, 8, 32'b11000011, 32'b00000010, 32'hFF, 32'hFF);

    // asynchronous reset mid high phase
    do_reset();
    step(0, 1, 8'd4);
    step(1, 0, 8'd0);
    step(1, 0, 8'd0);
    rst = 0;
    #1;
    chk("arst_clk", clk_out, 1'b0);
    chk("arst_rise", rise_stb, 1'b0);
    chk("arst_run", running, 1'b0);
    chk("arst_rdy", cfg_ready, 1'b1);
    @(posedge clk_in); #1;
    rst = 1;
    expect_seq("arst_restart", 1, 0, 8'd0, 3, 32'b101, 32'b101, 32'b111, 32'b111);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit e;
      bit v;
      logic [7:0] d;
      e = ($urandom_range(0, 15) == 0) ? !en : en;
      v = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 40) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      step(e, v, d);
    end
    en = 0;
    cfg_valid = 0;
    repeat (300) @(posedge clk_in);
    #1;
    chk("final_idle", running, 1'b0);

    @(negedge clk_in);
    started = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable, glitch-free clock-divider controller for the clock-generation path. It derives a 50 %-duty `clk_out` from `clk_in` with a runtime-selectable half-period. Ratio changes are accepted through a valid/ready handshake and applied only at a falling boundary of `clk_out`. Start and stop requests never produce a runt high pulse. The block sits between the configuration logic and any downstream consumer of a slow derived clock or strobe.

## Interface
- `CNT_W`, 8: width of the divide value and the half-period counter.
- `RST_DIV`, 1: divide value loaded at reset. Must be ≥ 1.

- `clk_in`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run request, level-sensitive.
- `cfg_valid`  in  1  new divide value offered.
- `cfg_div`  in  CNT_W  half-period length in `clk_in` cycles. 0 is treated as 1.
- `cfg_ready`  out  1  block can accept a config (`!pend`).
- `clk_out`  out  1  registered divided clock. Period is 2·div `clk_in` cycles.
- `rise_stb`  out  1  one-cycle pulse, high in the cycle `clk_out` becomes 1.
- `running`  out  1  high in RUN and STOP states.

## Operation
- Internal state:
  - `cur_div` (active value), `pend_div` and `pend` (staged change).
  - Down-counter `cnt` (CNT_W bits).
  - FSM with states IDLE, RUN, STOP.
- Reset (`rst` = 0, async): state IDLE, `clk_out` = 0, `rise_stb` = 0, `running` = 0, `pend` = 0 (so `cfg_ready` = 1), `cur_div` = RST_DIV, `cnt` = 0. Asserting reset mid-phase truncates the phase immediately; this is accepted.
- Config handshake: transfer occurs when `cfg_valid & cfg_ready`. A stored value of 0 is replaced by 1.
  - In IDLE: written directly to `cur_div`; `pend` stays 0.
  - In RUN or STOP: written to `pend_div`, and `pend` is set to 1, so `cfg_ready` = 0 until the change is applied.
- IDLE: `clk_out` is held at 0.
  - If `en` = 1, go to RUN: `clk_out` ← 1, `rise_stb` ← 1, `cnt` ← div−1.
  - "div" is `cfg_div` if a transfer happens in the same cycle, otherwise `cur_div`.
- RUN, when `cnt` ≠ 0: decrement `cnt`.
- RUN, when `cnt` = 0 (terminal): toggle `clk_out`.
  - Rising toggle: `rise_stb` ← 1, `cnt` ← `cur_div`−1.
  - Falling toggle with `pend` = 1: `cur_div` ← `pend_div`, `pend` ← 0, `cnt` ← `pend_div`−1.
  - Falling toggle otherwise: `cnt` ← `cur_div`−1.
- Stop request (`en` = 0 sampled in RUN):
  - If `clk_out` = 0: go to IDLE next edge; `cnt` ← 0; a pending config is applied to `cur_div`.
  - If `clk_out` = 1: go to STOP. Counting continues so the high phase completes at full length.
- STOP: counts as in RUN. At terminal, `clk_out` ← 0 and any pending config is applied.
  - `en` = 1 at that edge: go to RUN and reload `cnt`.
  - `en` = 0 at that edge: go to IDLE.
  - `en` toggling before terminal has no effect.
- Invariant: every high phase and every low phase of `clk_out` while running lasts exactly the active div cycles. Only the final low phase before IDLE is open-ended.

## Timing
- Start latency: `en` sampled high at edge k in IDLE → `clk_out` = 1 and `rise_stb` = 1 after edge k.
- Half-period: with div = d, `clk_out` changes on every d-th edge.
  - d = 1 toggles every cycle.
  - d = 2^CNT_W−1 is the maximum.
- Config latency (running): from the accept edge to the first falling boundary, at most 2·d_old cycles. `cfg_ready` returns to 1 in the cycle after that boundary.
- Stop latency: at most d_cur cycles from `en` falling to `clk_out` held 0 and `running` = 0.
- `rise_stb` is registered and aligned with `clk_out` rising. It never occurs in STOP or IDLE.

## Test plan
- Reset, then `cfg_div` = 3 in IDLE, then `en` = 1 → `clk_out` is 3 high / 3 low repeating, with `rise_stb` every 6 cycles.
- `cfg_div` = 0, then `en` = 1 → identical to div = 1: `clk_out` toggles every cycle, `rise_stb` every 2 cycles.
- Running at d = 3, accept `cfg_div` = 5 one cycle into a high phase → that high phase still lasts 3 cycles, then 5 low / 5 high. `cfg_ready` = 0 from the accept until after the falling edge.
- Running at d = 4, drop `en` one cycle after `clk_out` rises → high phase lasts 4 cycles, then `clk_out` = 0 held and `running` = 0.
- Same as above, but reassert `en` before the terminal count → no gap: normal 4 low / 4 high continues, and `running` stays 1.
- Assert `rst` = 0 mid high phase → `clk_out`, `rise_stb` and `running` go to 0 immediately; `cfg_ready` = 1; after release, restart uses RST_DIV.
